// File: rtl/sar_value_finder_if.sv
// Bus between the SAR value finder and its 4-bit comparator neighbour.
// The master side owns the request and comparator flags; the slave side is the finder.
interface sar_value_finder_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             ageqb;
   logic             aeqb;
   logic [WIDTH-1:0] probe;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             exact;

   modport master (
      output start, ageqb, aeqb,
      input  probe, busy, done, result, exact
   );

   modport slave (
      input  start, ageqb, aeqb,
      output probe, busy, done, result, exact
   );
endinterface

// File: rtl/sar_value_finder.sv
// Recovers the comparator's A operand by successive approximation on its B input,
// then confirms the final guess with one equality check before publishing it.
module sar_value_finder #(
   parameter int WIDTH = 4
) (
   input logic              clk,
   input logic              rst,
   sar_value_finder_if.slave bus
);
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, SEARCH, VERIFY, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] acc_q;
   logic [IDX_W-1:0] bit_idx_q;
   logic [WIDTH-1:0] result_q;
   logic             exact_q;
   logic             busy_q;
   logic             done_q;

   logic [WIDTH-1:0] trial_d;
   logic [WIDTH-1:0] probe_d;

   // The comparator is combinational, so the trial value must be on B within the same cycle.
   always_comb begin
      trial_d = acc_q | (WIDTH'(1) << bit_idx_q);
      probe_d = '0;
      case (state_q)
         SEARCH:  probe_d = trial_d;
         VERIFY:  probe_d = acc_q;
         default: probe_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         bit_idx_q <= IDX_W'(WIDTH - 1);
         result_q  <= '0;
         exact_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  acc_q     <= '0;
                  bit_idx_q <= IDX_W'(WIDTH - 1);
                  busy_q    <= 1'b1;
                  state_q   <= SEARCH;
               end
            end
            SEARCH: begin
               if (bus.ageqb) begin
                  acc_q <= trial_d;
               end
               if (bit_idx_q == '0) begin
                  state_q <= VERIFY;
               end else begin
                  bit_idx_q <= bit_idx_q - 1'b1;
               end
            end
            VERIFY: begin
               result_q <= acc_q;
               exact_q  <= bus.aeqb;
               busy_q   <= 1'b0;
               done_q   <= 1'b1;
               state_q  <= DONE;
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.probe  = probe_d;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.exact  = exact_q;
endmodule

// File: tb/tb_sar_value_finder.sv
// Drives the finder against a modelled combinational comparator and checks probes,
// handshake timing and the recovered value against a plain binary-search reference.
module tb_sar_value_finder;
   localparam int W    = 4;
   localparam int MASK = (1 << W) - 1;

   logic         clk;
   logic         rst;
   logic [W-1:0] a_val;
   int           compared;
   int           mismatched;
   int           exp_result_g;
   int           exp_exact_g;

   sar_value_finder_if #(.WIDTH(W)) bus ();

   sar_value_finder #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural 4-bit comparator: A is a_val, B is the finder's probe.
   always_comb begin
      bus.ageqb = (a_val >= bus.probe);
      bus.aeqb  = (a_val == bus.probe);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // One search: A starts as a1 and switches to a2 at the negedge of cycle sw (sw > W+1 means never).
   task automatic run_search(input string name, input int a1_in, input int a2_in, input int sw,
                             input bit mid_start, input bit done_start);
      int p[W];
      int acc;
      int av;
      int a1;
      int a2;
      int a_fin;
      int exp_res;
      int exp_ex;
      int prev_res;
      int prev_ex;
      a1 = a1_in & MASK;
      a2 = a2_in & MASK;
      acc = 0;
      for (int k = 0; k < W; k++) begin
         p[k] = acc + (1 << (W - 1 - k));
         av   = (k + 1 >= sw) ? a2 : a1;
         if (av >= p[k]) acc = p[k];
      end
      a_fin    = (W + 1 >= sw) ? a2 : a1;
      exp_res  = acc;
      exp_ex   = (acc == a_fin) ? 1 : 0;
      prev_res = exp_result_g;
      prev_ex  = exp_exact_g;

      a_val = W'(a1);
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      for (int c = 1; c <= W + 4; c++) begin
         @(negedge clk);
         if (c == sw) a_val = W'(a2);
         if (mid_start && c == 3) bus.start = 1'b1;
         if (mid_start && c == 4) bus.start = 1'b0;
         if (done_start && c == W + 2) bus.start = 1'b1;
         if (done_start && c == W + 3) bus.start = 1'b0;
         if (c <= W) begin
            check($sformatf("%s probe c%0d", name, c), 32'(bus.probe), 32'(p[c-1]));
            check($sformatf("%s busy c%0d", name, c), 32'(bus.busy), 32'd1);
            check($sformatf("%s done c%0d", name, c), 32'(bus.done), 32'd0);
            check($sformatf("%s held result c%0d", name, c), 32'(bus.result), 32'(prev_res));
            check($sformatf("%s held exact c%0d", name, c), 32'(bus.exact), 32'(prev_ex));
         end else if (c == W + 1) begin
            check($sformatf("%s verify probe", name), 32'(bus.probe), 32'(exp_res));
            check($sformatf("%s verify busy", name), 32'(bus.busy), 32'd1);
            check($sformatf("%s verify done", name), 32'(bus.done), 32'd0);
            check($sformatf("%s verify result", name), 32'(bus.result), 32'(prev_res));
         end else if (c == W + 2) begin
            check($sformatf("%s done pulse", name), 32'(bus.done), 32'd1);
            check($sformatf("%s done busy", name), 32'(bus.busy), 32'd0);
            check($sformatf("%s done probe", name), 32'(bus.probe), 32'd0);
            check($sformatf("%s result", name), 32'(bus.result), 32'(exp_res));
            check($sformatf("%s exact", name), 32'(bus.exact), 32'(exp_ex));
         end else begin
            check($sformatf("%s idle done c%0d", name, c), 32'(bus.done), 32'd0);
            check($sformatf("%s idle busy c%0d", name, c), 32'(bus.busy), 32'd0);
            check($sformatf("%s idle probe c%0d", name, c), 32'(bus.probe), 32'd0);
            check($sformatf("%s idle result c%0d", name, c), 32'(bus.result), 32'(exp_res));
         end
      end
      exp_result_g = exp_res;
      exp_exact_g  = exp_ex;
      $display("search %s: A=%0d->%0d expected result=%0d exact=%0d", name, a1, a2, exp_res, exp_ex);
   endtask

   initial begin
      int ra;
      int rb;
      int rs;
      compared     = 0;
      mismatched   = 0;
      exp_result_g = 0;
      exp_exact_g  = 0;
      rst          = 1'b1;
      bus.start    = 1'b0;
      a_val        = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset probe", 32'(bus.probe), 32'd0);
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset done", 32'(bus.done), 32'd0);
      check("reset result", 32'(bus.result), 32'd0);
      check("reset exact", 32'(bus.exact), 32'd0);
      rst = 1'b0;
      $display("reset: outputs checked");

      run_search("A10", 10, 10, 100, 1'b0, 1'b0);
      run_search("A0", 0, 0, 100, 1'b0, 1'b0);
      run_search("A15_start_in_done", 15, 15, 100, 1'b0, 1'b1);
      run_search("A20_trunc", 20, 20, 100, 1'b0, 1'b0);

      // Reset in the second SEARCH cycle discards the partial search and clears result.
      a_val = W'(12);
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst probe", 32'(bus.probe), 32'd0);
      check("midrst busy", 32'(bus.busy), 32'd0);
      check("midrst done", 32'(bus.done), 32'd0);
      check("midrst result", 32'(bus.result), 32'd0);
      check("midrst exact", 32'(bus.exact), 32'd0);
      rst = 1'b0;
      for (int c = 0; c < W + 3; c++) begin
         @(negedge clk);
         check($sformatf("midrst quiet done c%0d", c), 32'(bus.done), 32'd0);
         check($sformatf("midrst quiet busy c%0d", c), 32'(bus.busy), 32'd0);
      end
      exp_result_g = 0;
      exp_exact_g  = 0;
      $display("reset mid-search: outputs checked");
      run_search("A12_after_rst", 12, 12, 100, 1'b0, 1'b0);

      run_search("unstable_5_to_12", 5, 12, 2, 1'b1, 1'b0);

      for (int i = 0; i < 12; i++) begin
         ra = int'($urandom_range(0, MASK));
         if ($urandom_range(0, 3) == 0) begin
            rb = int'($urandom_range(0, MASK));
            rs = int'($urandom_range(1, W + 1));
         end else begin
            rb = ra;
            rs = 100;
         end
         run_search($sformatf("rand%0d", i), ra, rb, rs, ($urandom_range(0, 1) == 1), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/sar_value_finder.md
Name: sar_value_finder

Overview:
- Sequential consumer of the 4-bit comparator's outputs.
- Recovers an unknown operand A, held on the comparator's A input, by binary search. It drives the comparator's B input (probe) and reads back AgeqB and AeqB.
- Serves as the inverse of the comparator: the comparator reduces two numbers to relation flags, and this block rebuilds the number from those flags.
- Sits beside comparatorBehavior4bits in SOC_HW; the comparator is purely combinational between probe and the flags.

Parameters:
- WIDTH, 4: operand width in bits, for both probe and result; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a search; sampled only in IDLE.
- ageqb  input  1  comparator A>=B flag for the current probe.
- aeqb  input  1  comparator A==B flag for the current probe.
- probe  output  WIDTH  value driven onto comparator B.
- busy  output  1  high in SEARCH and VERIFY.
- done  output  1  one-cycle pulse when result and exact are updated.
- result  output  WIDTH  recovered A; holds between searches.
- exact  output  1  final probe equalled A (search is consistent).

Behaviour:
- The single clock is clk. Reset rst is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset values:
  - state = IDLE.
  - probe = 0, busy = 0, done = 0, result = 0, exact = 0.
  - Internal acc = 0, bit_idx = WIDTH-1.
- States: IDLE, SEARCH, VERIFY, DONE.
- IDLE:
  - probe = 0.
  - If start = 1 at an edge: acc <= 0, bit_idx <= WIDTH-1, go to SEARCH.
- SEARCH:
  - probe = acc | (1 << bit_idx), combinationally.
  - ageqb is sampled at the end of the same cycle, since the comparator is combinational.
  - At each edge, if ageqb = 1 then acc[bit_idx] <= 1.
  - If bit_idx = 0, go to VERIFY; otherwise bit_idx <= bit_idx - 1.
  - SEARCH lasts exactly WIDTH cycles.
- VERIFY:
  - probe = acc.
  - At the edge: result <= acc, exact <= aeqb, go to DONE.
- DONE:
  - done = 1 for this cycle only; probe = 0.
  - Next edge returns to IDLE unconditionally.
- Latency: start is accepted at edge E0. Probes appear in cycles 1..WIDTH, VERIFY occurs in cycle WIDTH+1, and done is high in cycle WIDTH+2 after E0.
- Back-to-back searches: a start held high in DONE is ignored, and one IDLE cycle always separates searches.
- start while busy or in DONE: ignored, with no restart and no queuing.
- result and exact change only at the VERIFY edge. They are stable at all other times, including during a new search.
- If A changes mid-search, the search continues on whatever flags arrive. The result is the last acc, and exact = 0 unless the final acc equals the new A.
- aeqb is ignored in SEARCH and ageqb is ignored in VERIFY.
- rst in any state, including mid-SEARCH, forces all reset values at that edge. The partial acc is discarded and result is cleared to 0.
- Width rule: A is a WIDTH-bit value, and the all-ones value is reachable (probe = 2^WIDTH - 1 at the final SEARCH cycle). No probe ever exceeds WIDTH bits.

Test Plan:
- A=10, pulse start:
  - probe sequence 8, 12, 10, 11, then 10 in VERIFY.
  - done in cycle 6 after accept; result=10, exact=1, busy high for cycles 1-5.
- A=0:
  - probes 8, 4, 2, 1, then 0; result=0, exact=1.
- A=15:
  - probes 8, 12, 14, 15, then 15; result=15, exact=1.
- A driven as 20 onto the 4-bit port (truncates to 4):
  - result=4, exact=1.
- Reset mid-search: A=12, start, then rst in cycle 2 of SEARCH.
  - Next cycle: state IDLE, probe=0, busy=0, result=0, done never pulses.
  - A fresh start then yields result=12.
- Unstable A and start while busy: A=5 for probe 1, then A=12.
  - probes 8, 4, 6, 7; result=7, exact=0.
  - A start pulse during SEARCH is ignored: done pulses exactly once.
